cpu_sequencer: RTL

Fetch/decode/write-back controller sitting directly upstream of the 4-bit ALU in the small CPU. Fetches 8-bit instructions from instruction memory over a req/ack handshake and drives the ALU's instruction and operand inputs. Captures the ALU's registered result and carry into the A/B registers and carry flag. Resolves the conditional jump itself.

---
 rtl/cpu_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/cpu_sequencer.sv
// Fetch/decode/write-back sequencer feeding the 4-bit ALU; resolves JNC locally.
// Optional single-step gating of instruction fetch is enabled by defining CPU_SEQ_STEP_EN.
module cpu_sequencer #(
  parameter logic [3:0] RESET_PC = 4'h0
) (
  input  logic       CLK,
  input  logic       RST_N,
  output logic       IMEM_REQ,
  output logic [3:0] IMEM_ADDR,
  input  logic       IMEM_ACK,
  input  logic [7:0] IMEM_DATA,
  output logic [3:0] ALU_INST,
  output logic [3:0] ALU_DATA1,
  output logic [3:0] ALU_DATA2,
  input  logic [3:0] ALU_OUT,
  input  logic       ALU_C,
  output logic [3:0] REG_A,
  output logic [3:0] REG_B,
  output logic       CARRY,
  output logic [3:0] PC_OUT
`ifdef CPU_SEQ_STEP_EN
  ,
  input  logic       STEP
`endif
);

  typedef enum logic [1:0] {StFetch, StDecode, StExec, StWb} state_e;

  state_e     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [3:0] reg_a_q, reg_a_d;
  logic [3:0] reg_b_q, reg_b_d;
  logic       carry_q, carry_d;
  logic [3:0] alu_inst_q, alu_inst_d;
  logic [3:0] alu_data1_q, alu_data1_d;
  logic [3:0] alu_data2_q, alu_data2_d;

  logic [3:0] opcode;
  logic [3:0] imm;
  logic       dest_a;
  logic       fetch_en;
  logic       req_int;
  logic       fetch_acc;

  assign opcode = ir_q[7:4];
  assign imm    = ir_q[3:0];
  // Move-from-B (0001) and all even opcodes target A; remaining odd opcodes target B.
  assign dest_a = (opcode == 4'b0001) | ~opcode[0];

`ifdef CPU_SEQ_STEP_EN
  logic step_q;
  logic pend_q, pend_d;

  // Rising edges collapse into one pending step, consumed when its fetch is accepted.
  assign pend_d   = (STEP & ~step_q) | (pend_q & ~fetch_acc);
  assign fetch_en = pend_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      step_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      step_q <= STEP;
      pend_q <= pend_d;
    end
  end
`else
  assign fetch_en = 1'b1;
`endif

  assign req_int   = (state_q == StFetch) & fetch_en;
  assign fetch_acc = req_int & IMEM_ACK;

  // Request drops as soon as reset asserts, independent of the clock.
  assign IMEM_REQ  = req_int & RST_N;
  assign IMEM_ADDR = pc_q;
  assign PC_OUT    = pc_q;
  assign REG_A     = reg_a_q;
  assign REG_B     = reg_b_q;
  assign CARRY     = carry_q;
  assign ALU_INST  = alu_inst_q;
  assign ALU_DATA1 = alu_data1_q;
  assign ALU_DATA2 = alu_data2_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    reg_a_d     = reg_a_q;
    reg_b_d     = reg_b_q;
    carry_d     = carry_q;
    alu_inst_d  = alu_inst_q;
    alu_data1_d = alu_data1_q;
    alu_data2_d = alu_data2_q;

    unique case (state_q)
      StFetch: begin
        if (fetch_acc) begin
          ir_d    = IMEM_DATA;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (opcode == 4'b0000) begin
          pc_d    = carry_q ? (pc_q + 4'd1) : imm;
          state_d = StFetch;
        end else begin
          alu_inst_d  = opcode;
          alu_data2_d = imm;
          case (opcode)
            4'b0001:          alu_data1_d = reg_b_q;
            4'b0010, 4'b0011: alu_data1_d = imm;
            default:          alu_data1_d = dest_a ? reg_a_q : reg_b_q;
          endcase
          state_d = StExec;
        end
      end
      StExec: begin
        // ALU samples the opcode on this edge; clear it so it never re-executes.
        alu_inst_d = 4'b0000;
        state_d    = StWb;
      end
      StWb: begin
        if (dest_a) begin
          reg_a_d = ALU_OUT;
        end else begin
          reg_b_d = ALU_OUT;
        end
        carry_d = ALU_C;
        pc_d    = pc_q + 4'd1;
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      ir_q        <= 8'h00;
      reg_a_q     <= 4'h0;
      reg_b_q     <= 4'h0;
      carry_q     <= 1'b0;
      alu_inst_q  <= 4'h0;
      alu_data1_q <= 4'h0;
      alu_data2_q <= 4'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      reg_a_q     <= reg_a_d;
      reg_b_q     <= reg_b_d;
      carry_q     <= carry_d;
      alu_inst_q  <= alu_inst_d;
      alu_data1_q <= alu_data1_d;
      alu_data2_q <= alu_data2_d;
    end
  end

endmodule
